// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the framebuffer port arbiter and its neighbours.
// Carries the display read channel, the game-logic write channel and the block-memory port.
// slave: arbiter side; master: environment side (address generator, writer, memory).
interface fb_port_arbiter_if #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // display read channel
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_pixel;
    logic              disp_pixel_valid;

    // game-logic write channel
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [LVL_W-1:0]  wr_level;

    // block-memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_dout,
        output disp_pixel, disp_pixel_valid, wr_ready, wr_level,
               mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_dout,
        input  disp_pixel, disp_pixel_valid, wr_ready, wr_level,
               mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Shares the single framebuffer memory port: display reads always win, writes are buffered and drained on idle cycles.
// Latency: mem_* one cycle after the decision; display pixel returned 2+MEM_LAT cycles after the request.
// Backpressure: wr_ready drops when the write buffer is full; continuous display reads stall the writer.
//
// Ports: clk, rst (synchronous, active-high), bus (fb_port_arbiter_if.slave):
//   disp_req/disp_addr -> disp_pixel/disp_pixel_valid, wr_valid/wr_addr/wr_data -> wr_ready/wr_level,
//   mem_en/mem_we/mem_addr/mem_din -> memory, mem_dout <- memory.
module fb_port_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    fb_port_arbiter_if.slave    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    // memory port registers
    logic              mem_en_q,   mem_en_d;
    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q,  mem_din_d;

    // read-return pipeline: bit 0 lines up with the cycle mem_en is presented for a read
    logic [MEM_LAT:0]  rd_vld_q,   rd_vld_d;
    logic [DATA_W-1:0] pix_q,      pix_d;
    logic              pix_vld_q,  pix_vld_d;

    // write buffer
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]  level_q,    level_d;

    logic push;
    logic pop;

    always_comb begin
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;

        // full/empty come from the registered count, so a pop never frees a slot
        // in the same cycle and a fresh push is never popped in its own cycle
        push = bus.wr_valid && (level_q != FULL_LVL);
        pop  = !bus.disp_req && (level_q != '0);

        if (bus.disp_req) begin
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.disp_addr;
        end else if (pop) begin
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = fifo_addr_q[rd_ptr_q];
            mem_din_d  = fifo_data_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end else begin
            // idle: address/data hold to avoid needless toggling on the memory bus
            mem_en_d   = 1'b0;
            mem_we_d   = 1'b0;
        end

        if (push) begin
            fifo_addr_d[wr_ptr_q] = bus.wr_addr;
            fifo_data_d[wr_ptr_q] = bus.wr_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        rd_vld_d  = {rd_vld_q[MEM_LAT-1:0], bus.disp_req};
        pix_vld_d = rd_vld_q[MEM_LAT];
        pix_d     = rd_vld_q[MEM_LAT] ? bus.mem_dout : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rd_vld_q    <= '0;
            pix_q       <= '0;
            pix_vld_q   <= 1'b0;
            fifo_addr_q <= '{default: '0};
            fifo_data_q <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rd_vld_q    <= rd_vld_d;
            pix_q       <= pix_d;
            pix_vld_q   <= pix_vld_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    assign bus.mem_en           = mem_en_q;
    assign bus.mem_we           = mem_we_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_din          = mem_din_q;
    assign bus.disp_pixel       = pix_q;
    assign bus.disp_pixel_valid = pix_vld_q;
    assign bus.wr_level         = level_q;
    assign bus.wr_ready         = (level_q != FULL_LVL);
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single port of the 12-bit framebuffer block memory between two requesters: the display pixel fetch, driven by the address generator during active video, and a game-logic writer that updates framebuffer pixels.
- Display reads always win. Writes are buffered in a small FIFO and drained in cycles where the display does not request.
- Sits between the address generator, the VGA colour output mux and the block memory, in the 25 MHz pixel clock domain.

Parameters:
- ADDR_W, 17, framebuffer address width
- DATA_W, 12, pixel width (RGB 4:4:4)
- FIFO_DEPTH, 4, write-buffer entries; power of 2, minimum 2
- MEM_LAT, 1, block-memory read latency in cycles (1 or 2)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  reset
- disp_req  in  1  display read request this cycle (asserted for active-video pixels)
- disp_addr  in  ADDR_W  display read address
- disp_pixel  out  DATA_W  returned pixel; 0 when disp_pixel_valid=0
- disp_pixel_valid  out  1  disp_pixel holds read data
- wr_valid  in  1  writer has a pixel to store
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_ready  out  1  FIFO can accept; transfer occurs when wr_valid && wr_ready
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data
- wr_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - mem_en, mem_we, mem_addr and mem_din are 0.
  - disp_pixel and disp_pixel_valid are 0.
  - The FIFO is empty: wr_level=0, wr_ready=1.
  - All read-pipeline valid bits are cleared.
- Arbitration is decided each cycle N from inputs sampled at N; the mem_* outputs are registered and take effect at N+1.
  - disp_req=1: mem_en=1, mem_we=0, mem_addr=disp_addr. The FIFO is not popped.
  - disp_req=0 and FIFO non-empty: pop the head. mem_en=1, mem_we=1, mem_addr/mem_din=head entry.
  - disp_req=0 and FIFO empty: mem_en=0, mem_we=0. mem_addr and mem_din hold their previous values.
- Read latency:
  - A display request accepted at cycle N appears on disp_pixel with disp_pixel_valid=1 at cycle N+2+MEM_LAT (3 cycles at the default).
  - A valid-bit shift register of length 1+MEM_LAT tracks requests. disp_pixel registers mem_dout when the tail bit is set, otherwise registers 0.
  - Back-to-back requests give one pixel per cycle, in order.
- FIFO:
  - wr_ready = (wr_level != FIFO_DEPTH), combinational from the count.
  - Push on wr_valid && wr_ready.
  - Push and pop in the same cycle leaves wr_level unchanged.
  - When full, wr_ready=0. A pop at N raises wr_ready at N+1; there is no same-cycle pass-through.
  - An empty FIFO with a push at N cannot be popped before N+1.
  - Write order to memory equals accept order.
  - Pointers wrap modulo FIFO_DEPTH. wr_level is never observed above FIFO_DEPTH or below 0.
- Starvation: continuous disp_req starves writes indefinitely; the FIFO stalls the writer via wr_ready. Writes drain during horizontal and vertical blanking.
- Hazard: a display read of an address with a pending FIFO write returns the old memory contents. No forwarding.
- Reset mid-operation:
  - Pending FIFO entries are discarded and never written.
  - In-flight reads are dropped; disp_pixel_valid=0 from the cycle after rst.
  - mem_en=0 and mem_we=0 from the cycle after rst.
- Writer signals while rst=1 are ignored.

Test Plan:
- Reset, then idle → mem_en=0, wr_ready=1, wr_level=0, disp_pixel=0.
- 640 consecutive disp_req cycles with addr 0..639, memory preloaded with data=addr[11:0] → disp_pixel sequence 0..639 starting 3 cycles after the first request, no gaps, mem_we never 1.
- disp_req held high, writer pushes 5 entries (addr 0x100..0x104) → 4 accepted, wr_ready=0 on the 5th, wr_level=4. Drop disp_req → 4 writes on 4 consecutive cycles in order, wr_ready=1 the cycle after the first pop, 5th accepted.
- Alternating disp_req 1/0 with 3 queued writes → each idle cycle carries exactly one write. Reads keep 3-cycle latency and order.
- Write addr 0x50 = 0xABC queued during active video, display reads 0x50 before the drain → old value returned. After the drain a read of 0x50 → 0xABC.
- Assert rst with 3 entries queued and 2 reads in flight → no mem_we afterwards, disp_pixel_valid=0, wr_level=0 the cycle after rst.
